data_memory_sized: RTL

- Parametrised, byte-addressed, little-endian data memory for the RV64 datapath; next generation of the plain data memory.
- Adds sized accesses (byte/half/word/double) with sign or zero extension and a registered read with a valid pulse.
- Adds alignment and range checking, and a hardware power-up initialisation sequencer that drives a ready flag.
- Sits between the ALU address output and the write-back mux.

---
 rtl/data_memory_sized.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/data_memory_sized.sv
// -----------------------------------------------------------------------------
// data_memory_sized
//
// Byte-addressed, little-endian data memory for the RV64 datapath. It supports
// sized loads and stores (byte/half/word/double), sign or zero extension on
// loads, and a registered read port with a one-cycle valid pulse. Alignment,
// size and range are checked on every request. After reset, a hardware
// sequencer rewrites the whole array with a known pattern. Mem_Ready stays low
// until that sequence has finished.
//
// Ports:
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   Mem_Addr      in   [ADDR_W-1:0] byte address
//   Write_Data    in   [DATA_W-1:0] store data (low N bytes used)
//   MemWrite      in   store request
//   MemRead       in   load request
//   Mem_Size      in   [1:0] access size, N = 1 << Mem_Size bytes
//   Mem_Unsigned  in   1 = zero-extend load, 0 = sign-extend
//   Mem_Ready     out  memory is accepting requests
//   Read_Data     out  [DATA_W-1:0] registered load result
//   Read_Valid    out  one-cycle pulse marking a new Read_Data
//   Mem_Error     out  registered error flag for the faulting request
//
// Request/response protocol: a request is taken on any rising edge where
// Mem_Ready is 1 and MemRead and/or MemWrite is 1. No back-pressure exists, so
// a request can be issued every cycle. The response (Read_Valid and/or
// Mem_Error) appears on the next edge and lasts exactly one cycle. Requests
// made while Mem_Ready is 0 are dropped and produce no response.
// -----------------------------------------------------------------------------
module data_memory_sized #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int DEPTH      = 64,
   parameter int INIT_BASE  = 9,
   parameter int INIT_COUNT = 53
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] Mem_Addr,
   input  logic [DATA_W-1:0] Write_Data,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic [1:0]        Mem_Size,
   input  logic              Mem_Unsigned,
   output logic              Mem_Ready,
   output logic [DATA_W-1:0] Read_Data,
   output logic              Read_Valid,
   output logic              Mem_Error
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_cnt;
   logic [7:0]         r_mem [DEPTH];

   logic [3:0]         w_n;
   logic [2:0]         w_align_mask;
   logic [ADDR_W:0]    w_end;
   logic               w_bad_size;
   logic               w_bad_align;
   logic               w_bad_range;
   logic               w_illegal;
   logic               w_active;
   logic               w_store;
   logic [IDX_W-1:0]   w_base;
   logic [DATA_W-1:0]  w_raw;
   logic               w_sign;
   logic [DATA_W-1:0]  w_load;
   logic [7:0]         w_init_byte;

   assign Mem_Ready = (r_state == ST_READY);

   // ---------------------------------------------------------------------------
   // Request legality
   // ---------------------------------------------------------------------------
   always_comb begin
      w_n          = 4'd1 << Mem_Size;
      w_align_mask = 3'd0;
      case (Mem_Size)
         2'd0:    w_align_mask = 3'b000;
         2'd1:    w_align_mask = 3'b001;
         2'd2:    w_align_mask = 3'b011;
         default: w_align_mask = 3'b111;
      endcase
      // One extra bit of headroom stops a huge address from wrapping into range.
      w_end       = {1'b0, Mem_Addr} + (ADDR_W+1)'(w_n);
      w_bad_size  = (DATA_W == 32) && (Mem_Size == 2'd3);
      w_bad_align = (Mem_Addr[2:0] & w_align_mask) != 3'd0;
      w_bad_range = w_end > (ADDR_W+1)'(DEPTH);
      w_illegal   = w_bad_size | w_bad_align | w_bad_range;
      w_active    = Mem_Ready & (MemRead | MemWrite);
      w_store     = Mem_Ready & MemWrite & ~w_illegal;
   end

   // ---------------------------------------------------------------------------
   // Load assembly and extension
   // ---------------------------------------------------------------------------
   assign w_base = Mem_Addr[IDX_W-1:0];

   always_comb begin
      w_raw = '0;
      // The byte index wraps. The wrapped value is used only when the access
      // is legal, and a legal access never actually crosses the array end.
      for (int k = 0; k < NB; k++) begin
         w_raw[8*k +: 8] = r_mem[IDX_W'(w_base + IDX_W'(k))];
      end
      w_sign = 1'b0;
      case (Mem_Size)
         2'd0:    w_sign = w_raw[7];
         2'd1:    w_sign = w_raw[15];
         2'd2:    w_sign = w_raw[31];
         default: w_sign = w_raw[DATA_W-1];
      endcase
      w_load = '0;
      for (int b = 0; b < DATA_W; b++) begin
         w_load[b] = (b < (8 << Mem_Size)) ? w_raw[b] : (w_sign & ~Mem_Unsigned);
      end
   end

   // Initialisation pattern: an incrementing byte sequence, then zeros.
   assign w_init_byte = (int'(r_cnt) < INIT_COUNT) ? 8'(INIT_BASE + int'(r_cnt)) : 8'd0;

   // ---------------------------------------------------------------------------
   // Memory array. Reset does not clear it; the INIT sequencer rewrites it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) begin
         r_mem[r_cnt] <= w_init_byte;
      end else if (w_store) begin
         for (int k = 0; k < NB; k++) begin
            if (k < int'(w_n)) begin
               r_mem[IDX_W'(w_base + IDX_W'(k))] <= Write_Data[8*k +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM and registered response
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_INIT;
         r_cnt      <= '0;
         Read_Data  <= '0;
         Read_Valid <= 1'b0;
         Mem_Error  <= 1'b0;
      end else begin
         Read_Valid <= 1'b0;
         Mem_Error  <= 1'b0;
         case (r_state)
            ST_INIT: begin
               if (r_cnt == IDX_W'(DEPTH - 1)) begin
                  r_state <= ST_READY;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               Mem_Error <= w_active & w_illegal;
               if (MemRead) begin
                  // The load sees pre-store contents because the array only
                  // updates on this same edge.
                  Read_Valid <= 1'b1;
                  Read_Data  <= w_illegal ? '0 : w_load;
               end
            end
         endcase
      end
   end

endmodule
